exe_stage: RTL and testbench

- Execute stage of the 5-stage turbo RISC-V pipeline, between decode (id_stage) and memory access (mem_stage).
- Latches decoded operands under valid/allowin handshake and computes the ALU result.
- Runs RV32M MUL (low 32 bits) on an iterative 32-cycle shift-add multiplier.
- Aligns store data to byte lanes, packs the exe-to-mem bus and drives the exe-to-id forwarding bus.

---
 rtl/exe_stage_pkg.sv | 68 ++++++
 rtl/exe_mul_iter.sv | 74 +++++++
 rtl/exe_stage.sv | 97 +++++++++
 tb/tb_exe_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU one-hot indices, multiplier FSM states and bus structs for exe_stage.
package exe_stage_pkg;

  localparam int ID_TO_EXE_DATA_WD  = 155;
  localparam int EXE_TO_MEM_DATA_WD = 111;
  localparam int EXE_TO_ID_FW_WD    = 72;
  localparam int MUL_CYCLES         = 32;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_LUI  = 10;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_MUL  = 2'd1,
    EX_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic        is_br;
    logic [2:0]  store_op;  // {sb, sh, sw}
    logic [4:0]  load_op;   // {lb, lbu, lh, lhu, lw}
    logic [4:0]  dest;
    logic        rf_wen;
    logic [10:0] alu_op;
    logic        mul;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rs2_val;
    logic [31:0] pc;
  } id_to_exe_t;

  typedef struct packed {
    logic        is_br;
    logic [2:0]  store_op;
    logic [4:0]  load_op;
    logic [4:0]  dest;
    logic        rf_wen;
    logic [31:0] wdata;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } exe_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ready_go;
    logic        load;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] result;
  } exe_to_id_fw_t;

  // Replicate the stored byte/half across all lanes; mem picks lanes by strobe.
  function automatic logic [31:0] align_store(input logic [2:0] store_op, input logic [31:0] v);
    if (store_op[2]) return {4{v[7:0]}};
    if (store_op[1]) return {2{v[15:0]}};
    return v;
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Low-32-bit multiplier: 32-iteration shift-add FSM, or a one-cycle product under EXE_FAST_MUL_EN.
// Result is held in DONE until the stage hands off; a start on the handoff edge reloads.
module exe_mul_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        handoff_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        done_o,
  output logic [31:0] product_o
);

`ifdef EXE_FAST_MUL_EN
  logic [31:0] product_q;
  logic        unused_handoff;

  assign unused_handoff = handoff_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
    end else if (start_i) begin
      product_q <= src1_i * src2_i;
    end
  end

  assign done_o    = 1'b1;
  assign product_o = product_q;
`else
  ex_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EX_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      state_q  <= EX_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= src1_i;
      mplier_q <= src2_i;
    end else begin
      case (state_q)
        EX_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'(MUL_CYCLES - 1)) state_q <= EX_DONE;
        end
        EX_DONE: if (handoff_i) state_q <= EX_IDLE;
        default: ;
      endcase
    end
  end

  assign done_o    = (state_q == EX_DONE);
  assign product_o = acc_q;
`endif

endmodule

// File: rtl/exe_stage.sv
// RISC-V execute stage: ALU 1 cycle after accept, MUL 32 cycles (1 under EXE_FAST_MUL_EN).
// Backpressure from mem_allowin holds all outputs and closes exe_allowin.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          id_to_exe_valid,
  input  id_to_exe_t    id_to_exe_data,
  output logic          exe_allowin,
  input  logic          mem_allowin,
  output logic          exe_to_mem_valid,
  output exe_to_mem_t   exe_to_mem_data,
  output exe_to_id_fw_t exe_to_id_fw_data
);

  logic        exe_valid_q;
  id_to_exe_t  in_q;
  logic        exe_ready_go;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;
  logic [31:0] alu_result;
  logic [31:0] exe_result;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [10:0] op;

  assign exe_allowin      = !exe_valid_q || (exe_ready_go && mem_allowin);
  assign exe_to_mem_valid = exe_valid_q && exe_ready_go;
  assign mul_start        = id_to_exe_valid && exe_allowin && id_to_exe_data.mul;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_q <= 1'b0;
      in_q        <= '0;
    end else if (exe_allowin) begin
      exe_valid_q <= id_to_exe_valid;
      if (id_to_exe_valid) in_q <= id_to_exe_data;
    end
  end

  exe_mul_iter u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .handoff_i (exe_to_mem_valid && mem_allowin),
    .src1_i    (id_to_exe_data.src1),
    .src2_i    (id_to_exe_data.src2),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign exe_ready_go = !in_q.mul || mul_done;

  assign a     = in_q.src1;
  assign b     = in_q.src2;
  assign shamt = in_q.src2[4:0];
  assign op    = in_q.alu_op;

  // alu_op is one-hot, so masking each result and OR-ing yields 0 for an empty op.
  assign alu_result = ({32{op[ALU_ADD]}}  & (a + b))
                    | ({32{op[ALU_SUB]}}  & (a - b))
                    | ({32{op[ALU_SLT]}}  & {31'd0, $signed(a) < $signed(b)})
                    | ({32{op[ALU_SLTU]}} & {31'd0, a < b})
                    | ({32{op[ALU_AND]}}  & (a & b))
                    | ({32{op[ALU_OR]}}   & (a | b))
                    | ({32{op[ALU_XOR]}}  & (a ^ b))
                    | ({32{op[ALU_SLL]}}  & (a << shamt))
                    | ({32{op[ALU_SRL]}}  & (a >> shamt))
                    | ({32{op[ALU_SRA]}}  & 32'($signed(a) >>> shamt))
                    | ({32{op[ALU_LUI]}}  & b);

  assign exe_result = in_q.mul ? mul_product : alu_result;

  assign exe_to_mem_data = '{
    is_br:      in_q.is_br,
    store_op:   in_q.store_op,
    load_op:    in_q.load_op,
    dest:       in_q.dest,
    rf_wen:     in_q.rf_wen,
    wdata:      align_store(in_q.store_op, in_q.rs2_val),
    alu_result: exe_result,
    pc:         in_q.pc
  };

  // ready_go is qualified by exe_valid so the bus reads all-zero out of reset.
  assign exe_to_id_fw_data = '{
    pc:       in_q.pc,
    ready_go: exe_valid_q && exe_ready_go,
    load:     |in_q.load_op,
    wen:      exe_valid_q && in_q.rf_wen,
    dest:     in_q.dest,
    result:   exe_result
  };

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: vector table through a scoreboard plus hand-written mul corner sequences.
module tb_exe_stage;
  import exe_stage_pkg::*;

`ifdef EXE_FAST_MUL_EN
  localparam int MUL_DUE = 0;
`else
  localparam int MUL_DUE = 32;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_to_exe_valid = 1'b0;
  id_to_exe_t    id_to_exe_data = '0;
  logic          exe_allowin;
  logic          mem_allowin = 1'b1;
  logic          exe_to_mem_valid;
  exe_to_mem_t   exe_to_mem_data;
  exe_to_id_fw_t exe_to_id_fw_data;

  exe_stage dut (
    .clk               (clk),
    .rst               (rst),
    .id_to_exe_valid   (id_to_exe_valid),
    .id_to_exe_data    (id_to_exe_data),
    .exe_allowin       (exe_allowin),
    .mem_allowin       (mem_allowin),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_to_mem_data   (exe_to_mem_data),
    .exe_to_id_fw_data (exe_to_id_fw_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] op;
    logic        mul;
    logic [2:0]  st;
    logic [4:0]  ld;
    logic [31:0] s1, s2, rs2, res, wd;
  } vec_t;

  typedef struct {
    exe_to_mem_t data;
    logic        is_load;
    int          due;
  } sb_t;

  sb_t  sb_q[$];
  logic seen = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int op_idx, input logic mul, input logic [2:0] st,
                               input logic [4:0] ld, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] rs2, input logic [31:0] res, input logic [31:0] wd);
    vec_t v;
    v.op  = (op_idx < 0) ? 11'd0 : (11'd1 << op_idx);
    v.mul = mul; v.st = st; v.ld = ld;
    v.s1 = s1; v.s2 = s2; v.rs2 = rs2; v.res = res; v.wd = wd;
    return v;
  endfunction

  function automatic id_to_exe_t mk_din(input vec_t v, input int idx);
    id_to_exe_t d;
    d          = '0;
    d.is_br    = (idx % 5 == 0);
    d.store_op = v.st;
    d.load_op  = v.ld;
    d.dest     = 5'(idx + 1);
    d.rf_wen   = (v.st == 3'b000);
    d.alu_op   = v.op;
    d.mul      = v.mul;
    d.src1     = v.s1;
    d.src2     = v.s2;
    d.rs2_val  = v.rs2;
    d.pc       = 32'h1000 + 32'(4 * idx);
    return d;
  endfunction

  function automatic exe_to_mem_t mk_exp(input id_to_exe_t d, input logic [31:0] res,
                                         input logic [31:0] wd);
    exe_to_mem_t e;
    e.is_br = d.is_br; e.store_op = d.store_op; e.load_op = d.load_op;
    e.dest = d.dest; e.rf_wen = d.rf_wen; e.wdata = wd; e.alu_result = res; e.pc = d.pc;
    return e;
  endfunction

  // Called at a negedge; returns one tick after the accept edge with cyc == accept cycle.
  task automatic send(input vec_t v, input int idx, output int acc_cyc);
    sb_t        e;
    id_to_exe_t d;
    int         budget;
    budget = 0;
    d = mk_din(v, idx);
    id_to_exe_valid = 1'b1;
    id_to_exe_data  = d;
    #1;
    while (!exe_allowin && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    acc_cyc = -1;
    if (!exe_allowin) begin
      checks++; failures++;
      $display("FAIL send_timeout vec=%0d exe_allowin=%0b required=1", idx, exe_allowin);
    end else begin
      acc_cyc   = cyc + 1;
      e.data    = mk_exp(d, v.res, v.wd);
      e.is_load = |v.ld;
      e.due     = acc_cyc + (v.mul ? MUL_DUE : 0);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    id_to_exe_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
      seen = 1'b0;
    end
  endtask

  // Monitor: latency and forwarding on first valid, full bus on handoff.
  initial begin
    sb_t           e;
    exe_to_id_fw_t fw;
    forever begin
      @(negedge clk); #2;
      if (!rst && exe_to_mem_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid pc=%0h required=no_output", exe_to_mem_data.pc);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("valid_cycle", 128'(cyc), 128'(sb_q[0].due));
            fw.pc = sb_q[0].data.pc; fw.ready_go = 1'b1; fw.load = sb_q[0].is_load;
            fw.wen = sb_q[0].data.rf_wen; fw.dest = sb_q[0].data.dest;
            fw.result = sb_q[0].data.alu_result;
            chk("fw_data", 128'(exe_to_id_fw_data), 128'(fw));
          end
          if (mem_allowin) begin
            e = sb_q.pop_front();
            chk("mem_data", 128'(exe_to_mem_data), 128'(e.data));
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    vec_t vt[18];
    vec_t v;
    int   acc;
    int   busy_bad;
    int   b;

    vt[0]  = mkv(ALU_ADD,  0, 3'b000, 5'b0, 32'd5,        32'hFFFFFFFF, 32'hCAFEF00D, 32'd4,        32'hCAFEF00D);
    vt[1]  = mkv(ALU_SUB,  0, 3'b000, 5'b0, 32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 32'h0);
    vt[2]  = mkv(ALU_SRA,  0, 3'b000, 5'b0, 32'h80000000, 32'd4,        32'h0,        32'hF8000000, 32'h0);
    vt[3]  = mkv(ALU_SRL,  0, 3'b000, 5'b0, 32'h80000000, 32'd4,        32'h0,        32'h08000000, 32'h0);
    vt[4]  = mkv(ALU_SLT,  0, 3'b000, 5'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        32'h0);
    vt[5]  = mkv(ALU_SLTU, 0, 3'b000, 5'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        32'h0);
    vt[6]  = mkv(ALU_AND,  0, 3'b000, 5'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 32'h0);
    vt[7]  = mkv(ALU_OR,   0, 3'b000, 5'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0, 32'h0);
    vt[8]  = mkv(ALU_XOR,  0, 3'b000, 5'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0, 32'h0);
    vt[9]  = mkv(ALU_SLL,  0, 3'b000, 5'b0, 32'd1,        32'h23,       32'h0,        32'd8,        32'h0);
    vt[10] = mkv(ALU_LUI,  0, 3'b000, 5'b0, 32'h0,        32'h12345000, 32'h0,        32'h12345000, 32'h0);
    vt[11] = mkv(-1,       0, 3'b000, 5'b0, 32'd7,        32'd9,        32'h0,        32'd0,        32'h0);
    vt[12] = mkv(-1,       1, 3'b000, 5'b0, 32'd7,        32'd6,        32'h0,        32'd42,       32'h0);
    vt[13] = mkv(-1,       1, 3'b000, 5'b0, 32'hFFFFFFFF, 32'd3,        32'h0,        32'hFFFFFFFD, 32'h0);
    vt[14] = mkv(ALU_ADD,  0, 3'b100, 5'b0, 32'h100,      32'd4,        32'h123456AB, 32'h104,      32'hABABABAB);
    vt[15] = mkv(ALU_ADD,  0, 3'b010, 5'b0, 32'h100,      32'd6,        32'h123456AB, 32'h106,      32'h56AB56AB);
    vt[16] = mkv(ALU_ADD,  0, 3'b001, 5'b0, 32'h100,      32'd8,        32'h123456AB, 32'h108,      32'h123456AB);
    vt[17] = mkv(ALU_ADD,  0, 3'b000, 5'b00001, 32'h200,  32'd8,        32'h0,        32'h208,      32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_allowin", 128'(exe_allowin), 128'(1));
    chk("rst_valid", 128'(exe_to_mem_valid), 128'(0));
    chk("rst_mem_data", 128'(exe_to_mem_data), 128'(0));
    chk("rst_fw_data", 128'(exe_to_id_fw_data), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      send(vt[i], i, acc);
    end
    drain();

`ifndef EXE_FAST_MUL_EN
    // Stage must stay closed and not forward-ready while iterating.
    @(negedge clk);
    send(vt[12], 20, acc);
    busy_bad = 0;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk); #2;
      if (exe_allowin || exe_to_mem_valid || exe_to_id_fw_data.ready_go) busy_bad++;
    end
    chk("mul_busy_cycles_bad", 128'(busy_bad), 128'(0));
    drain();
`endif

    // Backpressure in the result state, then a mul accepted on the handoff edge.
    @(negedge clk);
    mem_allowin = 1'b0;
    send(vt[13], 21, acc);
    b = 0;
    while (!exe_to_mem_valid && b < 80) begin
      @(negedge clk); #2;
      b++;
    end
    chk("bp_valid_seen", 128'(exe_to_mem_valid), 128'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("bp_data_hold", 128'(exe_to_mem_data),
          128'(mk_exp(mk_din(vt[13], 21), 32'hFFFFFFFD, 32'h0)));
      chk("bp_allowin", 128'(exe_allowin), 128'(0));
    end
    @(negedge clk);
    mem_allowin = 1'b1;
    v = mkv(-1, 1, 3'b000, 5'b0, 32'd9, 32'd11, 32'h0, 32'd99, 32'h0);
    send(v, 22, acc);
    drain();

`ifndef EXE_FAST_MUL_EN
    // Reset lands on iteration 10; the partial product must vanish.
    @(negedge clk);
    v = mkv(-1, 1, 3'b000, 5'b0, 32'h12345678, 32'h9ABCDEF1, 32'h0, 32'h0, 32'h0);
    send(v, 23, acc);
    b = 0;
    while (cyc < acc + 10 && b < 40) begin
      @(posedge clk);
      b++;
    end
    @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    seen = 1'b0;
    @(negedge clk); #2;
    chk("rst_mid_mul_valid", 128'(exe_to_mem_valid), 128'(0));
    chk("rst_mid_mul_allowin", 128'(exe_allowin), 128'(1));
    rst = 1'b0;
`endif

    @(negedge clk);
    v = mkv(ALU_ADD, 0, 3'b000, 5'b0, 32'd2, 32'd3, 32'h0, 32'd5, 32'h0);
    send(v, 24, acc);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
